// File: rtl/score_pkg.sv
// score_pkg: shared converter states and seven-segment glyphs for score_tracker_bcd
package score_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per cycle
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int SCORE_W = 7,
    parameter int DIGITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(SCORE_W) + 1;
    conv_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [SCORE_W-1:0] sh;
    logic [4*DIGITS-1:0] acc, adj;
    logic last_it;
    assign last_it = cnt == CW'(SCORE_W - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
                   state == SHIFT ? (last_it ? DONE : SHIFT) : IDLE;
    end
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sh  <= '0;
            acc <= '0;
            bcd <= '0;
        end else if (state == IDLE && start) begin
            cnt <= '0;
            sh  <= bin;
            acc <= '0;
        end else if (state == SHIFT) begin
            cnt       <= cnt + 1'b1;
            {acc, sh} <= {adj[4*DIGITS-2:0], sh, 1'b0};
        end else if (state == DONE) begin
            bcd <= acc;
        end
    end
endmodule

// File: rtl/score_tracker_bcd.sv
// score_tracker_bcd: collision-driven score/high score with BCD seven-segment display
module score_tracker_bcd
    import score_pkg::*;
#(
    parameter int DIGITS       = 2,
    parameter int SCORE_W      = 7,
    parameter int MAX_SCORE    = 99,
    parameter int PTS_PER_GOOD = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  goodColl,
    input  logic                  badColl,
    input  logic                  dispSel,
    input  logic                  clrHigh,
    output logic [SCORE_W-1:0]    currentScore,
    output logic [SCORE_W-1:0]    highScore,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcdValid,
    output logic [7*DIGITS-1:0]   ss,
    output logic                  maxReached
);
    logic good_q, bad_q, good_ev, bad_ev, busy, done, start;
    logic [SCORE_W:0] sum;
    logic [SCORE_W-1:0] cur_nx, high_nx, sel, snap, last_conv;
    assign good_ev = goodColl & ~good_q;
    assign bad_ev  = badColl & ~bad_q;
    // sum is one bit wider so the saturation compare never sees a wrapped value
    assign sum     = {1'b0, currentScore} + (SCORE_W+1)'(PTS_PER_GOOD);
    assign cur_nx  = bad_ev  ? '0 :
                     good_ev ? (sum > (SCORE_W+1)'(MAX_SCORE) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0]) :
                     currentScore;
    assign high_nx = clrHigh ? (good_ev ? cur_nx : '0) :
                     cur_nx > highScore ? cur_nx : highScore;
    assign maxReached = currentScore == SCORE_W'(MAX_SCORE);
    assign sel        = dispSel ? highScore : currentScore;
    assign start      = sel != last_conv;
    assign bcdValid   = !busy && !start;
    always_ff @(posedge clk) begin
        if (rst) begin
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            currentScore <= '0;
            highScore    <= '0;
            snap         <= '0;
            last_conv    <= '0;
        end else begin
            good_q       <= goodColl;
            bad_q        <= badColl;
            currentScore <= cur_nx;
            highScore    <= high_nx;
            if (!busy && start) snap <= sel;
            if (done) last_conv <= snap;
        end
    end
    bin2bcd_seq #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (sel),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );
    // a digit blanks only when it and everything above it is zero; digit 0 always shows
    always_comb begin
        ss = '0;
        for (int i = 0; i < DIGITS; i++)
            ss[7*i +: 7] = (i > 0 && (bcd >> (4*i)) == '0) ? SEG_BLANK :
                           bcd[4*i +: 4] > 4'd9 ? SEG_DASH : SEG_DIGIT[bcd[4*i +: 4]];
    end
endmodule

// File: tb/tb_score_tracker_bcd.sv
// tb_score_tracker_bcd: directed self-checking bench for score_tracker_bcd
module tb_score_tracker_bcd;
    localparam int DIGITS = 2, SCORE_W = 7, MAX_SCORE = 99;
    localparam logic [13:0] SS_ZERO = {7'b0000000, 7'b0111111};
    logic tb_clk = 1'b0;
    logic rst, goodColl, badColl, dispSel, clrHigh;
    logic [SCORE_W-1:0] currentScore, highScore;
    logic [4*DIGITS-1:0] bcd;
    logic bcdValid, maxReached;
    logic [7*DIGITS-1:0] ss;
    int n_checks = 0, n_fail = 0;

    always #5 tb_clk = ~tb_clk;

    score_tracker_bcd #(.DIGITS(DIGITS), .SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE), .PTS_PER_GOOD(1)) dut (
        .clk(tb_clk), .rst(rst), .goodColl(goodColl), .badColl(badColl), .dispSel(dispSel),
        .clrHigh(clrHigh), .currentScore(currentScore), .highScore(highScore), .bcd(bcd),
        .bcdValid(bcdValid), .ss(ss), .maxReached(maxReached)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic pulse_good();
        goodColl = 1'b1; tick();
        goodColl = 1'b0; tick();
    endtask

    task automatic wait_valid(input int max_cyc, output int took);
        took = 0;
        while (!bcdValid && took < max_cyc) begin
            tick();
            took++;
        end
    endtask

    function automatic int bcd_val(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic test_reset();
        rst = 1'b1; goodColl = 1'b0; badColl = 1'b0; dispSel = 1'b0; clrHigh = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if (currentScore !== 7'd0 || highScore !== 7'd0 || maxReached !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_scores: cur=%0d high=%0d max=%b, required 0 0 0", currentScore, highScore, maxReached);
        end
        n_checks++;
        if (bcd !== 8'h00 || bcdValid !== 1'b1 || ss !== SS_ZERO) begin
            n_fail++;
            $display("FAIL reset_display: bcd=%h valid=%b ss=%b, required 00 1 %b", bcd, bcdValid, ss, SS_ZERO);
        end
    endtask

    task automatic test_sequence();
        bit is_bad [7] = '{0, 0, 0, 0, 1, 0, 0};
        int exp_sc [7] = '{1, 2, 3, 4, 0, 1, 2};
        int took;
        for (int i = 0; i < 7; i++) begin
            if (is_bad[i]) badColl = 1'b1; else goodColl = 1'b1;
            tick();
            n_checks++;
            if (currentScore !== SCORE_W'(exp_sc[i])) begin
                n_fail++;
                $display("FAIL seq_step%0d: cur=%0d required %0d", i, currentScore, exp_sc[i]);
            end
            goodColl = 1'b0; badColl = 1'b0;
            tick();
        end
        n_checks++;
        if (highScore !== 7'd4) begin
            n_fail++;
            $display("FAIL seq_high: high=%0d required 4", highScore);
        end
        wait_valid(40, took);
        n_checks++;
        if (bcdValid !== 1'b1 || bcd !== 8'h02) begin
            n_fail++;
            $display("FAIL seq_bcd_cur: valid=%b bcd=%h required 1 02", bcdValid, bcd);
        end
        dispSel = 1'b1;
        #1;
        n_checks++;
        if (bcdValid !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_sel_invalid: valid=%b required 0", bcdValid);
        end
        wait_valid(SCORE_W + 4, took);
        n_checks++;
        if (bcdValid !== 1'b1 || took != SCORE_W + 2) begin
            n_fail++;
            $display("FAIL seq_latency: valid=%b cycles=%0d required 1 %0d", bcdValid, took, SCORE_W + 2);
        end
        n_checks++;
        if (bcd !== 8'h04 || ss !== {7'b0000000, 7'b1100110}) begin
            n_fail++;
            $display("FAIL seq_bcd_high: bcd=%h ss=%b required 04 %b", bcd, ss, {7'b0000000, 7'b1100110});
        end
    endtask

    task automatic test_held();
        dispSel = 1'b0;
        goodColl = 1'b1;
        repeat (20) tick();
        goodColl = 1'b0;
        tick();
        n_checks++;
        if (currentScore !== 7'd3 || highScore !== 7'd4) begin
            n_fail++;
            $display("FAIL held_level: cur=%0d high=%0d required 3 4", currentScore, highScore);
        end
    endtask

    task automatic test_simultaneous();
        pulse_good(); pulse_good();
        n_checks++;
        if (currentScore !== 7'd5 || highScore !== 7'd5) begin
            n_fail++;
            $display("FAIL simul_setup: cur=%0d high=%0d required 5 5", currentScore, highScore);
        end
        goodColl = 1'b1; badColl = 1'b1;
        tick();
        n_checks++;
        if (currentScore !== 7'd0 || highScore !== 7'd5) begin
            n_fail++;
            $display("FAIL simul_bad_wins: cur=%0d high=%0d required 0 5", currentScore, highScore);
        end
        goodColl = 1'b0; badColl = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        int took;
        repeat (98) pulse_good();
        n_checks++;
        if (currentScore !== 7'd98 || maxReached !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_98: cur=%0d max=%b required 98 0", currentScore, maxReached);
        end
        repeat (7) pulse_good();
        n_checks++;
        if (currentScore !== 7'd99 || maxReached !== 1'b1 || highScore !== 7'd99) begin
            n_fail++;
            $display("FAIL sat_99: cur=%0d max=%b high=%0d required 99 1 99", currentScore, maxReached, highScore);
        end
        wait_valid(40, took);
        n_checks++;
        if (bcdValid !== 1'b1 || bcd !== 8'h99 || ss !== {7'b1101111, 7'b1101111}) begin
            n_fail++;
            $display("FAIL sat_display: valid=%b bcd=%h ss=%b required 1 99 %b", bcdValid, bcd, ss, {7'b1101111, 7'b1101111});
        end
        clrHigh = 1'b1; tick(); clrHigh = 1'b0;
        n_checks++;
        if (highScore !== 7'd0) begin
            n_fail++;
            $display("FAIL clr_high: high=%0d required 0", highScore);
        end
        tick();
        badColl = 1'b1; tick(); badColl = 1'b0; tick();
        n_checks++;
        if (currentScore !== 7'd0 || highScore !== 7'd99) begin
            n_fail++;
            $display("FAIL bad_keeps_high: cur=%0d high=%0d required 0 99", currentScore, highScore);
        end
        clrHigh = 1'b1; goodColl = 1'b1; tick();
        clrHigh = 1'b0; goodColl = 1'b0;
        n_checks++;
        if (currentScore !== 7'd1 || highScore !== 7'd1) begin
            n_fail++;
            $display("FAIL clr_with_good: cur=%0d high=%0d required 1 1", currentScore, highScore);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int took;
        logic [7:0] prev;
        bit seen_invalid;
        dispSel = 1'b0;
        badColl = 1'b1; tick(); badColl = 1'b0; tick();
        wait_valid(40, took);
        n_checks++;
        if (bcdValid !== 1'b1 || bcd !== 8'h00 || ss !== SS_ZERO) begin
            n_fail++;
            $display("FAIL b2b_start: valid=%b bcd=%h ss=%b required 1 00 %b", bcdValid, bcd, ss, SS_ZERO);
        end
        prev = bcd;
        seen_invalid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            goodColl = (k % 3 == 0);
            tick();
            if (!bcdValid) seen_invalid = 1'b1;
            if (bcd !== prev) begin
                n_checks++;
                if (bcd_val(bcd) <= bcd_val(prev) || bcd_val(bcd) > int'(currentScore) || bcd[3:0] > 4'd9) begin
                    n_fail++;
                    $display("FAIL b2b_order: bcd=%h after %h with cur=%0d, required increasing value <= cur", bcd, prev, currentScore);
                end
                prev = bcd;
            end
        end
        goodColl = 1'b0;
        n_checks++;
        if (!seen_invalid) begin
            n_fail++;
            $display("FAIL b2b_invalid: bcdValid never 0, required 0 during conversion");
        end
        wait_valid(40, took);
        n_checks++;
        if (bcdValid !== 1'b1 || currentScore !== 7'd10 || bcd !== 8'h10 || ss !== {7'b0000110, 7'b0111111}) begin
            n_fail++;
            $display("FAIL b2b_final: valid=%b cur=%0d bcd=%h ss=%b required 1 10 10 %b", bcdValid, currentScore, bcd, ss, {7'b0000110, 7'b0111111});
        end
    endtask

    task automatic test_reset_mid_shift();
        goodColl = 1'b1; tick();
        goodColl = 1'b0; tick(); tick();
        n_checks++;
        if (bcdValid !== 1'b0 || bcd !== 8'h10) begin
            n_fail++;
            $display("FAIL mid_pre: valid=%b bcd=%h required 0 10", bcdValid, bcd);
        end
        rst = 1'b1; tick();
        n_checks++;
        if (bcd !== 8'h00 || currentScore !== 7'd0 || highScore !== 7'd0 || bcdValid !== 1'b1 || ss !== SS_ZERO) begin
            n_fail++;
            $display("FAIL mid_reset: bcd=%h cur=%0d high=%0d valid=%b ss=%b required 00 0 0 1 %b", bcd, currentScore, highScore, bcdValid, ss, SS_ZERO);
        end
        rst = 1'b0;
        repeat (SCORE_W + 3) tick();
        n_checks++;
        if (bcd !== 8'h00 || bcdValid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_idle: bcd=%h valid=%b required 00 1", bcd, bcdValid);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_held();
        test_simultaneous();
        test_saturate();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/score_tracker_bcd.md
Name: score_tracker_bcd

Overview:
Parametrised successor to the two-digit score tracker.
- Counts good and bad collision events and maintains a current score and a high score.
- Converts the selected score (current or high) to BCD with a sequential double-dabble engine, then drives one seven-segment pattern per digit with leading-zero blanking.
- Sits between the game collision logic and the board display.

Parameters:
DIGITS, 2, number of BCD digits and seven-segment outputs (1..4)
SCORE_W, 7, binary score width; must satisfy 2**SCORE_W > MAX_SCORE
MAX_SCORE, 99, saturation ceiling for currentScore; must be <= 10**DIGITS-1
PTS_PER_GOOD, 1, points added per good collision

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
goodColl  in  1  good-collision level; each rising edge counts once
badColl  in  1  bad-collision level; each rising edge counts once
dispSel  in  1  0 = display currentScore, 1 = display highScore
clrHigh  in  1  one-cycle strobe; clears highScore
currentScore  out  SCORE_W  current score
highScore  out  SCORE_W  best score since reset or clrHigh
bcd  out  4*DIGITS  BCD of the last converted value; digit 0 in bits [3:0]
bcdValid  out  1  1 when bcd equals the currently selected value and the converter is idle
ss  out  7*DIGITS  seven-segment patterns, active-high, bit order {g,f,e,d,c,b,a}, digit 0 in bits [6:0]
maxReached  out  1  1 while currentScore == MAX_SCORE

Behaviour:
- Reset, applied on the clk edge while rst=1:
  - currentScore=0, highScore=0, bcd=0, bcdValid=1, maxReached=0.
  - Edge-detect registers=0, converter state=IDLE.
  - ss digit 0 = 7'b0111111 ("0"); all other digits = 0 (blank).
  - Reset mid-conversion aborts the conversion immediately.
- Edge detect: register goodColl and badColl; an event is current=1 and previous=0. A held level counts once.
- Score update, registered, one cycle after the input rising edge:
  - Bad event: currentScore <= 0. A bad event wins over a simultaneous good event.
  - Good event only: currentScore <= min(currentScore + PTS_PER_GOOD, MAX_SCORE). Compute the sum in SCORE_W+1 bits before the compare, so there is no wrap-around.
  - highScore <= next currentScore whenever that value exceeds highScore (live tracking). A reset of currentScore never lowers highScore.
  - clrHigh: highScore <= 0. If a good event occurs in the same cycle, highScore <= next currentScore instead.
- maxReached is combinational from currentScore.
- Converter FSM (IDLE, SHIFT, DONE):
  - IDLE: when the selected value (mux of dispSel) != the last converted value, latch a snapshot and go to SHIFT.
  - SHIFT: runs exactly SCORE_W iterations. Each iteration first adds 3 to any BCD digit >= 5, then shifts {bcd_acc, bin} left by 1.
  - DONE: lasts one cycle; bcd <= accumulator, last-converted <= snapshot; go to IDLE.
  - Latency: SCORE_W+2 cycles from a selected-value change to the bcd update.
  - If the selected value changes during SHIFT, the conversion completes, then IDLE immediately restarts with the new value.
  - bcdValid = (state==IDLE) && (selected value == last converted value).
- Seven-segment decode is combinational from bcd:
  - Digits 0-9 use the standard active-high patterns.
  - Any higher digit that is 0, with all digits above it also 0, is blanked (7'b0).
  - Digit 0 is never blanked.
  - Codes 10-15 (unreachable) display 7'b1000000 ("-").

Decomposition:
- Package score_pkg:
  - conv_state_t enum {IDLE, SHIFT, DONE}.
  - SEG_DIGIT[0:9] pattern constant array.
  - SEG_BLANK and SEG_DASH constants.
- Sub-module bin2bcd_seq(SCORE_W, DIGITS) holds the converter FSM, with ports clk, rst, start, bin, busy, done, bcd.
- Edge detect, score logic and seven-segment decode stay in score_tracker_bcd.

Test Plan:
- Reset with dispSel=0 -> currentScore=0, highScore=0, bcd=8'h00, bcdValid=1, ss={7'b0, 7'b0111111}.
- 4 good pulses, 1 bad, 2 good -> currentScore sequence 1,2,3,4,0,1,2; highScore ends at 4. With dispSel=1, bcd=8'h04 after <= SCORE_W+2 cycles.
- goodColl held high for 20 cycles -> currentScore increments by exactly 1.
- Same-cycle rising edges on goodColl and badColl at score 5 -> currentScore=0, highScore stays 5.
- 105 good pulses (defaults) -> currentScore saturates at 99, maxReached=1, bcd=8'h99, ss tens = 7'b1101111 ("9").
- Good pulse every 3 cycles while dispSel=0 -> bcd only takes values 8'h01, 8'h02, ... in order; bcdValid=0 during conversion; final bcd matches currentScore once input stops. Assert rst mid-SHIFT -> next cycle bcd=0, state IDLE.
